// File: rtl/register_file.sv
// Register file with REGSIZE x BITSIZE storage: two combinational read ports, one write port.
// Synchronous active-high reset clears every register and takes priority over a write.
module register_file #(
   parameter int BITSIZE = 64,
   parameter int REGSIZE = 32
) (
   input  logic [$clog2(REGSIZE)-1:0] ReadSelect1,
   input  logic [$clog2(REGSIZE)-1:0] ReadSelect2,
   input  logic [$clog2(REGSIZE)-1:0] WriteSelect,
   input  logic [BITSIZE-1:0]         WriteData,
   input  logic                       WriteEnable,
   output logic [BITSIZE-1:0]         ReadData1,
   output logic [BITSIZE-1:0]         ReadData2,
   input  logic                       clk,
   input  logic                       rst
);

   localparam int SELW = $clog2(REGSIZE);

   logic [BITSIZE-1:0] regs [REGSIZE];

   // Out-of-range select values never match a loop index, so such writes drop
   always_ff @(posedge clk) begin
      for (int i = 0; i < REGSIZE; i++) begin
         if (rst) begin
            regs[i] <= '0;
         end else if (WriteEnable && (WriteSelect == SELW'(i))) begin
            regs[i] <= WriteData;
         end
      end
   end

   generate
      if (REGSIZE == (1 << SELW)) begin : gFullRange
         assign ReadData1 = regs[ReadSelect1];
         assign ReadData2 = regs[ReadSelect2];
      end else begin : gPartialRange
         logic inRange1;
         logic inRange2;

         assign inRange1  = (int'({1'b0, ReadSelect1}) < REGSIZE);
         assign inRange2  = (int'({1'b0, ReadSelect2}) < REGSIZE);
         assign ReadData1 = inRange1 ? regs[ReadSelect1] : '0;
         assign ReadData2 = inRange2 ? regs[ReadSelect2] : '0;
      end
   endgenerate

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset sweep, write sweep, dual read,
// write-disable, same-register read during write, and reset-vs-write.
module tb_register_file;

   logic [4:0]  readSelect1;
   logic [4:0]  readSelect2;
   logic [4:0]  writeSelect;
   logic [63:0] writeData;
   logic        writeEnable;
   logic [63:0] readData1;
   logic [63:0] readData2;
   logic        clk;
   logic        rst;

   int nVec;
   int nErr;

   register_file #(.BITSIZE(64), .REGSIZE(32)) dut (
      .ReadSelect1(readSelect1),
      .ReadSelect2(readSelect2),
      .WriteSelect(writeSelect),
      .WriteData  (writeData),
      .WriteEnable(writeEnable),
      .ReadData1  (readData1),
      .ReadData2  (readData2),
      .clk        (clk),
      .rst        (rst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
      nVec++;
      if (got !== exp) begin
         nErr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      nVec = 0;
      nErr = 0;
      rst = 1'b1;
      writeEnable = 1'b0;
      writeSelect = '0;
      writeData = '0;
      readSelect1 = '0;
      readSelect2 = '0;

      // reset, then every read-pair reads 0
      tick();
      rst = 1'b0;
      for (int a = 0; a < 32; a++) begin
         for (int b = 0; b < 32; b++) begin
            readSelect1 = 5'(a);
            readSelect2 = 5'(b);
            #1;
            checkVal("rstRd1", readData1, 64'd0);
            checkVal("rstRd2", readData2, 64'd0);
         end
      end

      // write sweep
      writeEnable = 1'b1;
      for (int k = 0; k < 32; k++) begin
         writeSelect = 5'(k);
         writeData = 64'(100 + 10 * k);
         tick();
      end
      writeEnable = 1'b0;
      for (int k = 0; k < 32; k++) begin
         readSelect1 = 5'(k);
         readSelect2 = 5'(31 - k);
         #1;
         checkVal("sweepRd1", readData1, 64'(100 + 10 * k));
         checkVal("sweepRd2", readData2, 64'(100 + 10 * (31 - k)));
      end

      // dual read, zero latency
      readSelect1 = 5'd3;
      readSelect2 = 5'd3;
      #1;
      checkVal("dualSame1", readData1, 64'd130);
      checkVal("dualSame2", readData2, 64'd130);
      readSelect2 = 5'd31;
      #1;
      checkVal("dualDiff1", readData1, 64'd130);
      checkVal("dualDiff2", readData2, 64'd410);

      // write disabled, including X strobe
      writeEnable = 1'b0;
      writeSelect = 5'd5;
      writeData = 64'hFFFF_FFFF_FFFF_FFFF;
      readSelect1 = 5'd5;
      repeat (3) tick();
      checkVal("weOff", readData1, 64'd150);
      writeEnable = 1'bx;
      repeat (2) tick();
      checkVal("weX", readData1, 64'd150);
      writeEnable = 1'b0;

      // same-register read across the write edge
      readSelect1 = 5'd7;
      readSelect2 = 5'd7;
      writeSelect = 5'd7;
      writeData = 64'hDEAD_BEEF_0000_0001;
      writeEnable = 1'b1;
      #1;
      checkVal("preEdge1", readData1, 64'd170);
      checkVal("preEdge2", readData2, 64'd170);
      tick();
      writeEnable = 1'b0;
      checkVal("postEdge1", readData1, 64'hDEAD_BEEF_0000_0001);
      checkVal("postEdge2", readData2, 64'hDEAD_BEEF_0000_0001);
      readSelect1 = 5'd6;
      readSelect2 = 5'd8;
      #1;
      checkVal("neighbor6", readData1, 64'd160);
      checkVal("neighbor8", readData2, 64'd180);

      // reg 0 is writable
      writeSelect = 5'd0;
      writeData = 64'h8000_0000_0000_0000;
      writeEnable = 1'b1;
      readSelect1 = 5'd0;
      tick();
      writeEnable = 1'b0;
      checkVal("reg0Wr", readData1, 64'h8000_0000_0000_0000);

      // reset wins over a simultaneous write
      rst = 1'b1;
      writeEnable = 1'b1;
      writeSelect = 5'd2;
      writeData = 64'd999;
      tick();
      rst = 1'b0;
      writeEnable = 1'b0;
      for (int k = 0; k < 32; k++) begin
         readSelect1 = 5'(k);
         readSelect2 = 5'(31 - k);
         #1;
         checkVal("rstWrRd1", readData1, 64'd0);
         checkVal("rstWrRd2", readData2, 64'd0);
      end

      // writes resume after reset release
      writeEnable = 1'b1;
      writeSelect = 5'd2;
      writeData = 64'd999;
      readSelect1 = 5'd2;
      tick();
      writeEnable = 1'b0;
      checkVal("postRstWr", readData1, 64'd999);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
